// File: rtl/reset_sequencer_if.sv
// Reset sequencer signal bundle: request/status inputs, domain reset outputs,
// retry count and a debug view of the sequencer state.
// There is no valid/ready handshake on this bundle. Every input is a level
// that is sampled on each rising clk edge. Every output is a registered level
// that changes only on that edge.
interface reset_sequencer_if;
    logic       i_hard_req;
    logic       i_soft_req;
    logic       i_pll_locked;
    logic       i_mem_ready;
    logic       o_pll_reset;
    logic       o_mem_reset;
    logic       o_core_reset;
    logic       o_soft_reset;
    logic       o_ready;
    logic [3:0] o_retries;
    logic [2:0] o_state;

    // Sequencer side.
    modport master (
        input  i_hard_req, i_soft_req, i_pll_locked, i_mem_ready,
        output o_pll_reset, o_mem_reset, o_core_reset, o_soft_reset,
        output o_ready, o_retries, o_state
    );

    // Environment side: reset sources and the reset consumers.
    modport slave (
        output i_hard_req, i_soft_req, i_pll_locked, i_mem_ready,
        input  o_pll_reset, o_mem_reset, o_core_reset, o_soft_reset,
        input  o_ready, o_retries, o_state
    );
endinterface

// File: rtl/reset_sequencer.sv
// Multi-stage reset controller. It releases the PLL, memory-controller and
// core resets in order, restarts on a hard request, lock loss or lock timeout,
// and runs a core-only soft reset from RUN.
module reset_sequencer #(
    parameter int STAGE_HOLD   = 16,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int SOFT_HOLD    = 8
) (
    input  logic              clk,
    input  logic              i_reset,
    reset_sequencer_if.master bus
);
    localparam int CNT_MAX = (LOCK_TIMEOUT > SOFT_HOLD) ? LOCK_TIMEOUT : SOFT_HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int LW      = $clog2(STAGE_HOLD + 1);

    localparam logic [CW-1:0] STAGE_LAST   = CW'(STAGE_HOLD - 1);
    localparam logic [CW-1:0] SOFT_LAST    = CW'(SOFT_HOLD - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_SAT      = CW'(CNT_MAX);
    localparam logic [LW-1:0] LOCK_LAST    = LW'(STAGE_HOLD - 1);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        MEM_WAIT  = 3'd2,
        CORE_HOLD = 3'd3,
        RUN       = 3'd4,
        SOFT      = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [3:0]    retries_q, retries_d;
    logic          pll_q, pll_d;
    logic          mem_q, mem_d;
    logic          core_q, core_d;
    logic          soft_q, soft_d;
    logic          ready_q, ready_d;
    logic          enter;

    // Next state. Priority order: hard request, lock loss, memory loss, stage exit, soft request.
    always_comb begin
        state_d   = state_q;
        enter     = 1'b0;
        retries_d = retries_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == STAGE_LAST) begin
                    state_d = WAIT_LOCK;
                    enter   = 1'b1;
                end
            end
            WAIT_LOCK: begin
                // A qualified lock on the timeout edge still counts as an exit.
                if (bus.i_pll_locked && (lock_cnt_q == LOCK_LAST)) begin
                    state_d = MEM_WAIT;
                    enter   = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = PLL_RST;
                    enter     = 1'b1;
                    retries_d = (retries_q == 4'hF) ? retries_q : retries_q + 4'd1;
                end
            end
            MEM_WAIT: begin
                if (!bus.i_pll_locked) begin
                    state_d = PLL_RST;
                    enter   = 1'b1;
                end else if (bus.i_mem_ready) begin
                    state_d = CORE_HOLD;
                    enter   = 1'b1;
                end
            end
            CORE_HOLD: begin
                if (!bus.i_pll_locked) begin
                    state_d = PLL_RST;
                    enter   = 1'b1;
                end else if (!bus.i_mem_ready) begin
                    state_d = MEM_WAIT;
                    enter   = 1'b1;
                end else if (cnt_q == STAGE_LAST) begin
                    state_d = RUN;
                    enter   = 1'b1;
                end
            end
            RUN: begin
                if (!bus.i_pll_locked) begin
                    state_d = PLL_RST;
                    enter   = 1'b1;
                end else if (!bus.i_mem_ready) begin
                    state_d = MEM_WAIT;
                    enter   = 1'b1;
                end else if (bus.i_soft_req) begin
                    state_d = SOFT;
                    enter   = 1'b1;
                end
            end
            SOFT: begin
                if (!bus.i_pll_locked) begin
                    state_d = PLL_RST;
                    enter   = 1'b1;
                end else if (!bus.i_mem_ready) begin
                    state_d = MEM_WAIT;
                    enter   = 1'b1;
                end else if (cnt_q == SOFT_LAST) begin
                    state_d = RUN;
                    enter   = 1'b1;
                end
            end
            default: begin
                state_d = PLL_RST;
                enter   = 1'b1;
            end
        endcase
        // A hard request re-enters PLL_RST every edge it is held and pre-empts a timeout count.
        if (bus.i_hard_req) begin
            state_d   = PLL_RST;
            enter     = 1'b1;
            retries_d = retries_q;
        end
    end

    // Stage counter restarts on every entry. The lock counter only runs while WAIT_LOCK is held.
    always_comb begin
        cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
        lock_cnt_d = '0;
        if (enter) begin
            cnt_d = '0;
        end else if ((state_q == WAIT_LOCK) && bus.i_pll_locked) begin
            lock_cnt_d = lock_cnt_q + LW'(1);
        end
    end

    // Output levels for the state being entered, so outputs register with the state.
    always_comb begin
        pll_d   = 1'b1;
        mem_d   = 1'b1;
        core_d  = 1'b1;
        soft_d  = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            WAIT_LOCK: pll_d = 1'b0;
            MEM_WAIT, CORE_HOLD: begin
                pll_d = 1'b0;
                mem_d = 1'b0;
            end
            RUN: begin
                pll_d   = 1'b0;
                mem_d   = 1'b0;
                core_d  = 1'b0;
                ready_d = 1'b1;
            end
            SOFT: begin
                pll_d  = 1'b0;
                mem_d  = 1'b0;
                soft_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counters and registered outputs, with a synchronous reset to the PLL_RST values.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q    <= PLL_RST;
            cnt_q      <= '0;
            lock_cnt_q <= '0;
            retries_q  <= '0;
            pll_q      <= 1'b1;
            mem_q      <= 1'b1;
            core_q     <= 1'b1;
            soft_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lock_cnt_q <= lock_cnt_d;
            retries_q  <= retries_d;
            pll_q      <= pll_d;
            mem_q      <= mem_d;
            core_q     <= core_d;
            soft_q     <= soft_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.o_pll_reset  = pll_q;
    assign bus.o_mem_reset  = mem_q;
    assign bus.o_core_reset = core_q;
    assign bus.o_soft_reset = soft_q;
    assign bus.o_ready      = ready_q;
    assign bus.o_retries    = retries_q;
    assign bus.o_state      = state_q;
endmodule
